// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic inter-stage pipeline register with stall tap, bubble/flush,
// saturating event counters, registered PC-match trigger and sticky illegal-stall flag.
module pipe_stage_reg #(
    parameter int PC_W           = 32,
    parameter int INST_W         = 32,
    parameter int STALL_W        = 6,
    parameter int STAGE          = 2,
    parameter int CNT_W          = 16,
    parameter int ZERO_ON_BUBBLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INST_W-1:0]  in_inst,
    input  logic               in_valid,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    output logic [PC_W-1:0]    out_pc,
    output logic [INST_W-1:0]  out_inst,
    output logic               out_valid,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   cnt_stall,
    output logic [CNT_W-1:0]   cnt_bubble,
    output logic [CNT_W-1:0]   cnt_flush,
    input  logic               dbg_en,
    input  logic [PC_W-1:0]    dbg_pc,
    input  logic               dbg_clr,
    output logic               dbg_hit,
    output logic               dbg_hit_sticky,
    output logic               err_stall
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_BUBBLE,
        ACT_FLUSH,
        ACT_HOLD
    } act_e;

    logic up;
    logic dn;
    act_e act;
    logic kill;
    logic load;
    logic illegal;
    logic match;

    assign up = stall[STAGE-1];
    assign dn = stall[STAGE];

    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (up && !dn) begin
            act = ACT_BUBBLE;
        end else if (up && dn) begin
            act = ACT_HOLD;
        end
    end

    assign kill    = (act == ACT_FLUSH) || (act == ACT_BUBBLE);
    assign load    = (act == ACT_LOAD);
    // A non-monotone vector (downstream stalled, upstream moving) still loads but is flagged.
    assign illegal = !up && dn;
    assign match   = load && in_valid && dbg_en && (in_pc == dbg_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc    <= '0;
            out_inst  <= '0;
            out_valid <= 1'b0;
        end else if (kill) begin
            out_valid <= 1'b0;
            if (ZERO_ON_BUBBLE != 0) begin
                out_pc   <= '0;
                out_inst <= '0;
            end
        end else if (load) begin
            out_pc    <= in_pc;
            out_inst  <= in_inst;
            out_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_stall  <= '0;
            cnt_bubble <= '0;
            cnt_flush  <= '0;
        end else begin
            if (act == ACT_FLUSH && cnt_flush != CNT_MAX) begin
                cnt_flush <= cnt_flush + CNT_W'(1);
            end
            if (act == ACT_BUBBLE && cnt_bubble != CNT_MAX) begin
                cnt_bubble <= cnt_bubble + CNT_W'(1);
            end
            if (act == ACT_HOLD && cnt_stall != CNT_MAX) begin
                cnt_stall <= cnt_stall + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_hit        <= 1'b0;
            dbg_hit_sticky <= 1'b0;
            err_stall      <= 1'b0;
        end else begin
            dbg_hit <= match;
            if (match) begin
                dbg_hit_sticky <= 1'b1;
            end else if (dbg_clr) begin
                dbg_hit_sticky <= 1'b0;
            end
            if (illegal) begin
                err_stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, zeroing and holding bubble variants.
module tb_pipe_stage_reg;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_valid = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        dbg_en = 1'b0;
    logic [31:0] dbg_pc = '0;
    logic        dbg_clr = 1'b0;

    logic [31:0] z_pc, z_inst, h_pc, h_inst;
    logic        z_valid, h_valid;
    logic [CW-1:0] z_cs, z_cb, z_cf, h_cs, h_cb, h_cf;
    logic        z_hit, z_sticky, z_err, h_hit, h_sticky, h_err;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CNT_W(CW), .ZERO_ON_BUBBLE(1)) dut_z (
        .clk(clk), .rst(rst), .in_pc(in_pc), .in_inst(in_inst), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_pc(z_pc), .out_inst(z_inst), .out_valid(z_valid),
        .cnt_clr(cnt_clr), .cnt_stall(z_cs), .cnt_bubble(z_cb), .cnt_flush(z_cf),
        .dbg_en(dbg_en), .dbg_pc(dbg_pc), .dbg_clr(dbg_clr), .dbg_hit(z_hit),
        .dbg_hit_sticky(z_sticky), .err_stall(z_err)
    );

    pipe_stage_reg #(.CNT_W(CW), .ZERO_ON_BUBBLE(0)) dut_h (
        .clk(clk), .rst(rst), .in_pc(in_pc), .in_inst(in_inst), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_pc(h_pc), .out_inst(h_inst), .out_valid(h_valid),
        .cnt_clr(cnt_clr), .cnt_stall(h_cs), .cnt_bubble(h_cb), .cnt_flush(h_cf),
        .dbg_en(dbg_en), .dbg_pc(dbg_pc), .dbg_clr(dbg_clr), .dbg_hit(h_hit),
        .dbg_hit_sticky(h_sticky), .err_stall(h_err)
    );

    typedef struct {
        logic [31:0] pc_z, inst_z, pc_h, inst_h;
        logic        valid;
        int          cs, cb, cf;
        logic        hit, sticky, err;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the register slot and counters as plain values, stepped per cycle.
    task automatic model_step();
        bit up, dn, hit;
        if (rst) begin
            m = '{pc_z: 0, inst_z: 0, pc_h: 0, inst_h: 0, valid: 0, cs: 0, cb: 0, cf: 0,
                  hit: 0, sticky: 0, err: 0};
            return;
        end
        up  = stall[1];
        dn  = stall[2];
        hit = !flush && !up && in_valid && dbg_en && (in_pc == dbg_pc);
        if (!up && dn) m.err = 1;
        if (flush || (up && !dn)) begin
            m.valid  = 0;
            m.pc_z   = 0;
            m.inst_z = 0;
        end else if (!up) begin
            m.valid  = in_valid;
            m.pc_z   = in_pc;
            m.inst_z = in_inst;
            m.pc_h   = in_pc;
            m.inst_h = in_inst;
        end
        if (cnt_clr) begin
            m.cs = 0; m.cb = 0; m.cf = 0;
        end else if (flush) begin
            if (m.cf < CMAX) m.cf++;
        end else if (up && !dn) begin
            if (m.cb < CMAX) m.cb++;
        end else if (up && dn) begin
            if (m.cs < CMAX) m.cs++;
        end
        m.hit = hit;
        if (hit) m.sticky = 1;
        else if (dbg_clr) m.sticky = 0;
    endtask

    task automatic step(input logic r, input logic [5:0] st, input logic fl,
                        input logic [31:0] pc, input logic [31:0] inst, input logic v,
                        input logic cc, input logic de, input logic [31:0] dpc, input logic dc);
        @(negedge clk);
        rst = r; stall = st; flush = fl; in_pc = pc; in_inst = inst; in_valid = v;
        cnt_clr = cc; dbg_en = de; dbg_pc = dpc; dbg_clr = dc;
        model_step();
        sb.push_back(m);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("z_pc", z_pc, e.pc_z);
                chk("z_inst", z_inst, e.inst_z);
                chk("z_valid", 32'(z_valid), 32'(e.valid));
                chk("h_pc", h_pc, e.pc_h);
                chk("h_inst", h_inst, e.inst_h);
                chk("h_valid", 32'(h_valid), 32'(e.valid));
                chk("cnt_stall", 32'(z_cs), 32'(e.cs));
                chk("cnt_bubble", 32'(z_cb), 32'(e.cb));
                chk("cnt_flush", 32'(z_cf), 32'(e.cf));
                chk("h_cnts", {20'd0, h_cs, h_cb, h_cf}, {20'd0, 4'(e.cs), 4'(e.cb), 4'(e.cf)});
                chk("dbg_hit", {z_hit, h_hit}, {e.hit, e.hit});
                chk("dbg_sticky", {z_sticky, h_sticky}, {e.sticky, e.sticky});
                chk("err_stall", {z_err, h_err}, {e.err, e.err});
            end
        end
    end

    initial begin : stim
        logic [5:0]  st;
        logic [31:0] pc;
        int          k;
        int          wait_cycles;

        // reset then load
        step(1, 6'b0, 0, 32'h100, 32'h13, 1, 0, 0, 0, 0);
        step(1, 6'b0, 0, 32'h100, 32'h13, 1, 0, 0, 0, 0);
        step(0, 6'b0, 0, 32'h100, 32'h13, 1, 0, 0, 0, 0);
        // upstream stalled, downstream moving: bubbles
        repeat (3) step(0, 6'b000011, 0, 32'h104, 32'h33, 1, 0, 0, 0, 0);
        // reload then hold, then flush while stalled
        step(0, 6'b0, 0, 32'h108, 32'h93, 1, 0, 0, 0, 0);
        repeat (4) step(0, 6'b000111, 0, 32'h10c, 32'h73, 1, 0, 0, 0, 0);
        step(0, 6'b000111, 1, 32'h10c, 32'h73, 1, 0, 0, 0, 0);
        // debug match, no match under hold, clear collides with a new match
        step(0, 6'b0, 0, 32'h102F0, 32'hA5, 1, 0, 1, 32'h102F0, 0);
        step(0, 6'b000111, 0, 32'h102F0, 32'hA5, 1, 0, 1, 32'h102F0, 0);
        step(0, 6'b0, 1, 32'h102F0, 32'hA5, 1, 0, 1, 32'h102F0, 0);
        step(0, 6'b0, 0, 32'h102F0, 32'hA6, 1, 0, 1, 32'h102F0, 1);
        step(0, 6'b0, 0, 32'h200, 32'hA7, 1, 0, 1, 32'h102F0, 1);
        // saturation, then clear beating a hold increment
        repeat (20) step(0, 6'b000111, 0, 32'h300, 32'h1, 1, 0, 0, 0, 0);
        step(0, 6'b000111, 0, 32'h300, 32'h1, 1, 1, 0, 0, 0);
        // illegal stall pattern loads and sets a sticky flag
        step(0, 6'b000100, 0, 32'h400, 32'h2, 1, 0, 0, 0, 0);
        repeat (3) step(0, 6'b0, 0, 32'h404, 32'h3, 1, 0, 0, 0, 0);
        step(1, 6'b0, 0, 32'h404, 32'h3, 1, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            k  = $urandom_range(0, 6);
            st = 6'((7'd1 << k) - 7'd1);
            if ($urandom_range(0, 7) == 0) st = 6'($urandom);
            case ($urandom_range(0, 3))
                0: pc = 32'h100;
                1: pc = 32'h104;
                2: pc = 32'h102F0;
                default: pc = $urandom;
            endcase
            step($urandom_range(0, 39) == 0, st, $urandom_range(0, 9) == 0, pc, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0, 32'h102F0, $urandom_range(0, 7) == 0);
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
